// File: rtl/RSA_pkg.sv
// Shared RSA types: operand width, key type, Montgomery operand bundles and the
// state encoding of the Montgomery pre-computation block.
package RSA_pkg;

    localparam int unsigned MOD_WIDTH = 256;
    localparam int unsigned CNT_WIDTH = $clog2(2 * MOD_WIDTH + 1);

    typedef logic [MOD_WIDTH-1:0] KeyType;

    typedef struct packed {
        KeyType base;
        KeyType msg;
        KeyType key;
        KeyType modulus;
    } RSAMontModIn;

    typedef struct packed {
        KeyType msg;
        KeyType key;
        KeyType modulus;
    } RSAPrepIn;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } prep_state_e;

    // Moduli for which a Montgomery base is meaningless.
    function automatic logic mod_is_bad(input KeyType modulus);
        return !modulus[0] || (modulus < KeyType'(3));
    endfunction

endpackage

// File: rtl/rsa_mont_prep_if.sv
// Request/response handshake of the Montgomery pre-computation block; the o_*
// side matches the exponentiator input port so it can be wired straight through.
interface rsa_mont_prep_if;
    import RSA_pkg::*;

    logic        i_valid;
    logic        i_ready;
    RSAPrepIn    i_in;
    logic        o_valid;
    logic        o_ready;
    RSAMontModIn o_out;

    modport slave (
        input  i_valid, i_in, o_ready,
        output i_ready, o_valid, o_out
    );

    modport master (
        output i_valid, i_in, o_ready,
        input  i_ready, o_valid, o_out
    );

endinterface

// File: rtl/rsa_mod_double.sv
// One modular doubling step: r_next = 2*r mod modulus, assuming r < modulus.
module rsa_mod_double
    import RSA_pkg::*;
(
    input  logic [MOD_WIDTH:0] r,
    input  KeyType             modulus,
    output logic [MOD_WIDTH:0] r_next
);

    logic [MOD_WIDTH:0] t;
    logic [MOD_WIDTH:0] m_ext;

    always_comb begin
        t      = r << 1;
        m_ext  = {1'b0, modulus};
        r_next = (t >= m_ext) ? (t - m_ext) : t;
    end

endmodule

// File: rtl/rsa_mont_prep.sv
// Computes base = 2^(2*MOD_WIDTH) mod modulus by repeated doubling and hands the
// packed operand set to the exponentiator. Optional: RSA_PREP_MOD_CHECK_EN.
module rsa_mont_prep
    import RSA_pkg::*;
(
    input logic             clk,
    input logic             rst_n,
    rsa_mont_prep_if.slave  bus
);

    localparam logic [CNT_WIDTH-1:0] LastStep = CNT_WIDTH'(2 * MOD_WIDTH - 1);

    prep_state_e          state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [MOD_WIDTH:0]   r_q, r_d, r_dbl;
    RSAPrepIn             req_q, req_d;

    rsa_mod_double u_dbl (
        .r       (r_q),
        .modulus (req_q.modulus),
        .r_next  (r_dbl)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        req_d   = req_q;
        unique case (state_q)
            StIdle: begin
                if (bus.i_valid) begin
                    req_d   = bus.i_in;
                    cnt_d   = '0;
                    // modulus == 1 starts from residue 0 so the result is 0
                    r_d     = '0;
                    r_d[0]  = (bus.i_in.modulus != KeyType'(1));
                    state_d = StCalc;
`ifdef RSA_PREP_MOD_CHECK_EN
                    if (mod_is_bad(bus.i_in.modulus)) begin
                        r_d     = '0;
                        state_d = StDone;
                    end
`endif
                end
            end
            StCalc: begin
                r_d   = r_dbl;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastStep) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.o_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            r_q     <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            req_q   <= req_d;
        end
    end

    assign bus.i_ready = (state_q == StIdle);
    assign bus.o_valid = (state_q == StDone);

    always_comb begin
        bus.o_out = '0;
        if (state_q == StDone) begin
            bus.o_out.base    = r_q[MOD_WIDTH-1:0];
            bus.o_out.msg     = req_q.msg;
            bus.o_out.key     = req_q.key;
            bus.o_out.modulus = req_q.modulus;
        end
    end

endmodule

// File: tb/tb_rsa_mont_prep.sv
// Self-checking bench for rsa_mont_prep: directed requests, a modular-arithmetic
// reference model with a scoreboard, and a per-cycle output/handshake monitor.
module tb_rsa_mont_prep;
    import RSA_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    rsa_mont_prep_if bus ();

    rsa_mont_prep dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        RSAMontModIn out;
        bit          base_known;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    RSAMontModIn last_out;
    int          xfer_cyc = 0;
    int          acc_cyc = 0;
    bit          seen_valid = 0;

    task automatic check(input string name, input KeyType act, input KeyType exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out at cycle %0d, expected event", name, cyc);
    endtask

    function automatic RSAPrepIn mk(input KeyType msg, input KeyType key, input KeyType modulus);
        RSAPrepIn r;
        r.msg = msg;
        r.key = key;
        r.modulus = modulus;
        return r;
    endfunction

    // Reference: base = 2^(2*MOD_WIDTH) mod modulus via wide integer arithmetic.
    function automatic RSAMontModIn model(input RSAPrepIn req);
        logic [2*MOD_WIDTH:0] p, m, rem;
        RSAMontModIn o;
        p = '0;
        p[2*MOD_WIDTH] = 1'b1;
        m = '0;
        m[MOD_WIDTH-1:0] = req.modulus;
        rem = (m == 0) ? '0 : (p % m);
        o.base = rem[MOD_WIDTH-1:0];
`ifdef RSA_PREP_MOD_CHECK_EN
        if (!req.modulus[0] || req.modulus < 3) o.base = '0;
`endif
        o.msg = req.msg;
        o.key = req.key;
        o.modulus = req.modulus;
        return o;
    endfunction

    function automatic int latency(input RSAPrepIn req);
`ifdef RSA_PREP_MOD_CHECK_EN
        if (!req.modulus[0] || req.modulus < 3) return 1;
`endif
        return 2 * MOD_WIDTH + 1;
    endfunction

    // Monitor: handshake rules and outputs against the scoreboard every cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            seen_valid = 0;
            check("rst_i_ready", KeyType'(bus.i_ready), KeyType'(1));
            check("rst_o_valid", KeyType'(bus.o_valid), KeyType'(0));
            check("rst_o_base", bus.o_out.base, '0);
            check("rst_o_modulus", bus.o_out.modulus, '0);
        end else begin
            check("i_ready", KeyType'(bus.i_ready), KeyType'(exp_q.size() == 0));
            if (exp_q.size() == 0) begin
                check("no_stale_o_valid", KeyType'(bus.o_valid), KeyType'(0));
            end else begin
                if (!seen_valid && cyc == exp_q[0].due)
                    check("o_valid_rise", KeyType'(bus.o_valid), KeyType'(1));
                if (bus.o_valid) begin
                    if (!seen_valid) begin
                        check("latency", KeyType'(cyc), KeyType'(exp_q[0].due));
                        seen_valid = 1;
                    end
                    if (exp_q[0].base_known)
                        check("o_base", bus.o_out.base, exp_q[0].out.base);
                    check("o_msg", bus.o_out.msg, exp_q[0].out.msg);
                    check("o_key", bus.o_out.key, exp_q[0].out.key);
                    check("o_modulus", bus.o_out.modulus, exp_q[0].out.modulus);
                    if (bus.o_ready) begin
                        last_out = bus.o_out;
                        xfer_cyc = cyc;
                        void'(exp_q.pop_front());
                        seen_valid = 0;
                    end
                end
            end
            if (bus.i_valid && bus.i_ready) begin
                exp_t e;
                e.out = model(bus.i_in);
                e.base_known = (bus.i_in.modulus != 0);
                e.due = cyc + latency(bus.i_in);
                exp_q.push_back(e);
                acc_cyc = cyc;
            end
        end
    end

    task automatic wait_accept(input bit keep, input RSAPrepIn next);
        bit done = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (bus.i_ready && bus.i_valid) begin
                @(posedge clk);
                #1;
                if (keep) bus.i_in = next;
                else bus.i_valid = 1'b0;
                done = 1;
            end
        end
        if (!done) timeout("accept");
    endtask

    task automatic send(input RSAPrepIn req, input bit keep, input RSAPrepIn next);
        bus.i_valid = 1'b1;
        bus.i_in = req;
        wait_accept(keep, next);
    endtask

    task automatic wait_xfer();
        bit done = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (bus.o_valid && bus.o_ready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        if (!done) timeout("transfer");
    endtask

    task automatic run_one(input string name, input RSAPrepIn req, input KeyType exp_base);
        send(req, 1'b0, mk(0, 0, 0));
        wait_xfer();
        check({name, "_base"}, last_out.base, exp_base);
        check({name, "_msg"}, last_out.msg, req.msg);
        check({name, "_key"}, last_out.key, req.key);
        check({name, "_modulus"}, last_out.modulus, req.modulus);
    endtask

    KeyType      m_a, m_max, exp10;
    RSAMontModIn held;
    int          xfer_a;

    initial begin
        m_max = '1;
        m_a = m_max - KeyType'(188);
`ifdef RSA_PREP_MOD_CHECK_EN
        exp10 = '0;
`else
        exp10 = KeyType'(6);
`endif
        bus.i_valid = 1'b0;
        bus.i_in = '0;
        bus.o_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Pin the reference model against hand-computed values.
        held = model(mk(5, 3, m_a));
        check("model_m_a", held.base, KeyType'(35721));
        held = model(mk(0, 0, m_max));
        check("model_m_max", held.base, KeyType'(1));
        held = model(mk(0, 0, 7));
        check("model_m7", held.base, KeyType'(4));
        held = model(mk(0, 0, 10));
        check("model_m10", held.base, exp10);

        run_one("m_a", mk(5, 3, m_a), KeyType'(35721));
        run_one("m_max", mk(17, 65537, m_max), KeyType'(1));
        run_one("m7", mk(2, 3, 7), KeyType'(4));
        run_one("m1", mk(0, 1, 1), KeyType'(0));
        run_one("m10", mk(3, 7, 10), exp10);

        // Back-pressure: output must hold while o_ready is low.
        bus.o_ready = 1'b0;
        send(mk(6, 5, 7), 1'b0, mk(0, 0, 0));
        for (int i = 0; i < 2000 && !bus.o_valid; i++) @(negedge clk);
        if (!bus.o_valid) timeout("hold_o_valid");
        held = bus.o_out;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold_o_valid", KeyType'(bus.o_valid), KeyType'(1));
            check("hold_i_ready", KeyType'(bus.i_ready), KeyType'(0));
            check("hold_base", bus.o_out.base, held.base);
            check("hold_msg", bus.o_out.msg, held.msg);
        end
        check("hold_value", held.base, KeyType'(4));
        @(posedge clk);
        #1 bus.o_ready = 1'b1;
        wait_xfer();
        @(negedge clk);
        check("i_ready_after_xfer", KeyType'(bus.i_ready), KeyType'(1));
        check("o_valid_after_xfer", KeyType'(bus.o_valid), KeyType'(0));

        // Reset during CALC discards the computation.
        send(mk(5, 3, m_a), 1'b0, mk(0, 0, 0));
        repeat (100) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (600) @(posedge clk);
        #1;
        run_one("after_rst", mk(4, 9, 7), KeyType'(4));

        // Back-to-back with i_valid held high; i_in changes right after accept.
        send(mk(1, 2, 7), 1'b1, mk(9, 11, m_max));
        wait_accept(1'b0, mk(0, 0, 0));
        xfer_a = xfer_cyc;
        check("b2b_first_base", last_out.base, KeyType'(4));
        check("b2b_first_msg", last_out.msg, KeyType'(1));
        check("b2b_accept_gap", KeyType'(acc_cyc), KeyType'(xfer_a + 1));
        wait_xfer();
        check("b2b_second_base", last_out.base, KeyType'(1));
        check("b2b_second_key", last_out.key, KeyType'(11));

        repeat (5) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rsa_mont_prep.md
RSA_MONT_PREP -- requirements
Module: rsa_mont_prep

Interface
REQ-001 Parameters: none; all widths SHALL come from RSA_pkg (MOD_WIDTH, KeyType).
REQ-002 clk  input  1  clock; all state SHALL update on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_valid  input  1  request valid.
REQ-005 i_ready  output  1  request accepted when i_valid && i_ready.
REQ-006 i_in  input  RSAPrepIn  {msg, key, modulus}, each KeyType.
REQ-007 o_valid  output  1  packed operand set valid.
REQ-008 o_ready  input  1  downstream Montgomery exponentiator ready.
REQ-009 o_out  output  RSAMontModIn  {base, msg, key, modulus}; base = 2^(2*MOD_WIDTH) mod modulus.

Function
REQ-010 FSM SHALL have states IDLE, CALC, DONE; i_ready SHALL be 1 only in IDLE, o_valid SHALL be 1 only in DONE.
REQ-011 IDLE: on i_valid && i_ready, SHALL latch msg, key, modulus, set residue r = 1 (MOD_WIDTH+1 bits), clear step counter, go to CALC.
REQ-012 CALC: each cycle SHALL compute t = 2*r; r <= (t >= modulus) ? t - modulus : t; counter +1.
REQ-013 Arithmetic SHALL use MOD_WIDTH+1 bits for t so 2*r < 2*modulus never overflows; exactly one conditional subtraction per step.
REQ-014 Counter SHALL be $clog2(2*MOD_WIDTH+1) bits; after the step with counter == 2*MOD_WIDTH-1 the FSM SHALL enter DONE (exactly 2*MOD_WIDTH steps).
REQ-015 Latency: o_valid SHALL rise 2*MOD_WIDTH+1 rising edges after the accepting edge (inclusive of the accepting edge).
REQ-016 DONE: o_out SHALL hold base = r[MOD_WIDTH-1:0] and latched msg, key, modulus unchanged while o_valid && !o_ready.
REQ-017 DONE with o_ready: SHALL return to IDLE; i_ready SHALL rise next cycle (no same-cycle accept/output bypass).
REQ-018 i_valid during CALC/DONE SHALL be ignored; i_in changes after acceptance SHALL not affect the result.
REQ-019 modulus == 1 SHALL yield base = 0 (initial r = 0 when modulus == 1).
REQ-020 msg and key SHALL be passed through unmodified; msg < modulus is not checked.

Reset
REQ-021 On rst_n low, at any state including mid-CALC: state IDLE, i_ready = 1, o_valid = 0, o_out = 0, r = 0, counter = 0.
REQ-022 A computation interrupted by reset SHALL be discarded; no output for it SHALL appear after reset release.

Configuration
REQ-023 Macro RSA_PREP_MOD_CHECK_EN: when defined, an accepted modulus that is even or < 3 SHALL skip CALC, enter DONE the next cycle with base = 0 (latency 1 edge after acceptance).
REQ-024 Without RSA_PREP_MOD_CHECK_EN, every modulus SHALL go through CALC; result for modulus == 0 is unspecified but the handshake SHALL still complete at normal latency.

Structure
REQ-025 RSA_pkg SHALL hold MOD_WIDTH, KeyType, RSAMontModIn and new typedef RSAPrepIn {msg, key, modulus}.
REQ-026 One combinational sub-module rsa_mod_double SHALL implement the step (r, modulus) -> 2r mod modulus.
REQ-027 o_out/o_valid/o_ready SHALL connect directly to the Montgomery exponentiator's input port without glue.

Verification
REQ-028 modulus = 2^256-189, msg = 5, key = 3, o_ready = 1 -> base = 35721 (0x8B89), msg/key/modulus echoed, o_valid after 513 edges.
REQ-029 modulus = 2^256-1 -> base = 1; modulus = 7 -> base = 4; modulus = 1 -> base = 0.
REQ-030 Hold o_ready = 0 for 20 cycles in DONE -> o_valid stays 1, o_out constant, i_ready = 0 throughout; release -> one transfer, i_ready = 1 next cycle.
REQ-031 Assert rst_n low at step 100 of CALC, then new request modulus = 7 -> only base = 4 output observed, no stale output.
REQ-032 With RSA_PREP_MOD_CHECK_EN, modulus = 10 -> base = 0 one edge after acceptance; without it, modulus = 10 -> base = 6 at normal latency.
REQ-033 Back-to-back requests with i_valid held high -> second accepted exactly one cycle after first output transfer.
